f64_promote_f32_unit: RTL

//  Multi-cycle f64.promote_f32 converter for the CPU FPU path: the inverse of f32.demote_f64.

---
 rtl/f64_promote_f32_unit_if.sv | 22 ++
 rtl/f64_promote_f32_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/f64_promote_f32_unit_if.sv
// Operand and result channels of the f32 -> f64 promote unit.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high.
// A source holds valid and data stable until that edge. A sink may drive ready freely.
interface f64_promote_f32_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/f64_promote_f32_unit.sv
// Multi-cycle f64.promote_f32: widens a binary32 operand to the exact binary64 value.
// Subnormal operands are normalised one bit per cycle.
module f64_promote_f32_unit #(
  parameter bit SUBNORMAL_EN = 1'b1,
  parameter bit CANON_NAN    = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  f64_promote_f32_unit_if.slave         bus,
  output logic [1:0]                    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [22:0] man_q, man_d;
  logic [4:0]  k_q, k_d;
  logic        sign_q, sign_d;
  logic [63:0] out_q, out_d;

  logic [23:0] man_shl;
  logic [4:0]  k_inc;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;

  // Every operand that needs no normalisation loop is converted in one step.
  // A zero exponent here is either a true zero or a subnormal being flushed.
  function automatic logic [63:0] pack_direct(input logic [31:0] x);
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] r;
    s = x[31];
    e = x[30:23];
    f = x[22:0];
    if (e == 8'd0) begin
      r = {s, 63'd0};
    end else if (e == 8'hFF) begin
      if (f == 23'd0) begin
        r = {s, 11'h7FF, 52'd0};
      end else if (CANON_NAN) begin
        r = {s, 63'h7FF8000000000000};
      end else begin
        r = {s, 11'h7FF, 1'b1, f[21:0], 29'd0};
      end
    end else begin
      r = {s, {3'd0, e} + 11'd896, f, 29'd0};
    end
    return r;
  endfunction

  assign in_exp  = bus.in_data[30:23];
  assign in_frac = bus.in_data[22:0];
  assign man_shl = {man_q, 1'b0};
  assign k_inc   = k_q + 5'd1;

  always_comb begin
    state_d = state_q;
    man_d   = man_q;
    k_d     = k_q;
    sign_d  = sign_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_data[31];
          if (SUBNORMAL_EN && (in_exp == 8'd0) && (in_frac != 23'd0)) begin
            man_d   = in_frac;
            k_d     = 5'd0;
            state_d = S_NORM;
          end else begin
            out_d   = pack_direct(bus.in_data);
            state_d = S_DONE;
          end
        end
      end
      S_NORM: begin
        man_d = man_shl[22:0];
        k_d   = k_inc;
        // The shift that brings the leading one to bit 23 also packs the result.
        if (man_shl[23]) begin
          out_d   = {sign_q, 11'd897 - {6'd0, k_inc}, man_shl[22:0], 29'd0};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      man_q   <= 23'd0;
      k_q     <= 5'd0;
      sign_q  <= 1'b0;
      out_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      man_q   <= man_d;
      k_q     <= k_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = out_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule
